clock_set_hms: RTL



---
 rtl/clock_set_hms_if.sv | 23 ++
 rtl/clock_set_hms.sv | 111 +++++++++++
 2 files changed

// File: rtl/clock_set_hms_if.sv
// Button inputs and time/display outputs of the time-of-day and set controller.
// Buttons are plain levels (no handshake); every output is a registered state value.
interface clock_set_hms_if;
    logic       mode_btn;
    logic       inc_btn;
    logic       dec_btn;
    logic [5:0] secs;
    logic [5:0] mins;
    logic [5:0] hours;
    logic [1:0] enable;
    logic [1:0] mode;
    logic       sec_tick;

    modport master (
        output mode_btn, inc_btn, dec_btn,
        input  secs, mins, hours, enable, mode, sec_tick
    );

    modport slave (
        input  mode_btn, inc_btn, dec_btn,
        output secs, mins, hours, enable, mode, sec_tick
    );
endinterface

// File: rtl/clock_set_hms.sv
// 1 Hz hours/minutes/seconds counter with a button-driven set mode.
// The selected field blinks through the enable blank code.
module clock_set_hms #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int BLINK_TICKS   = 12500000
) (
    input  logic           clk,
    input  logic           reset,
    clock_set_hms_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_SEC  = 2'b01,
        SET_MIN  = 2'b10,
        SET_HOUR = 2'b11
    } mode_t;

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    // Button vectors are ordered {dec, inc, mode}.
    logic [2:0]    sync1, sync2, prev, pulse;
    mode_t         mode_q, mode_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [BW-1:0] blink_cnt, blink_nx;
    logic          phase, phase_nx;
    logic [5:0]    secs_q, mins_q, hours_q;
    logic [1:0]    enable_q;
    logic          sec_tick_q;
    logic          mode_p, inc_p, dec_p, edit, presc_last;

    function automatic logic [5:0] step(input logic [5:0] v, input logic [5:0] last,
                                        input logic up);
        if (up) return (v == last) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? last : v - 6'd1;
    endfunction

    always_comb begin
        mode_p     = pulse[0];
        // A lone inc or dec is an edit; any pairing with another pulse drops it.
        inc_p      = (pulse == 3'b010);
        dec_p      = (pulse == 3'b100);
        edit       = (mode_q != RUN) && (inc_p || dec_p);
        presc_last = (presc == PRESC_LAST);
        mode_nx    = mode_p ? mode_t'(mode_q + 2'd1) : mode_q;
        presc_nx   = (presc_last || (mode_p && mode_nx == RUN)) ? '0 : presc + PW'(1);
        if (mode_nx == RUN || mode_p || edit) begin
            blink_nx = '0;
            phase_nx = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_nx = '0;
            phase_nx = ~phase;
        end else begin
            blink_nx = blink_cnt + BW'(1);
            phase_nx = phase;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            pulse      <= '0;
            mode_q     <= RUN;
            presc      <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            enable_q   <= 2'b00;
            sec_tick_q <= 1'b0;
            secs_q     <= '0;
            mins_q     <= '0;
            hours_q    <= '0;
        end else begin
            sync1      <= {bus.dec_btn, bus.inc_btn, bus.mode_btn};
            sync2      <= sync1;
            prev       <= sync2;
            pulse      <= sync2 & ~prev;
            mode_q     <= mode_nx;
            presc      <= presc_nx;
            blink_cnt  <= blink_nx;
            phase      <= phase_nx;
            enable_q   <= phase_nx ? mode_nx : RUN;
            sec_tick_q <= presc_last;
            if (mode_q == RUN) begin
                if (presc_last) begin
                    secs_q <= step(secs_q, 6'd59, 1'b1);
                    if (secs_q == 6'd59) begin
                        mins_q <= step(mins_q, 6'd59, 1'b1);
                        if (mins_q == 6'd59) hours_q <= step(hours_q, 6'd23, 1'b1);
                    end
                end
            end else if (edit) begin
                case (mode_q)
                    SET_SEC: secs_q  <= step(secs_q, 6'd59, inc_p);
                    SET_MIN: mins_q  <= step(mins_q, 6'd59, inc_p);
                    default: hours_q <= step(hours_q, 6'd23, inc_p);
                endcase
            end
        end
    end

    assign bus.secs     = secs_q;
    assign bus.mins     = mins_q;
    assign bus.hours    = hours_q;
    assign bus.enable   = enable_q;
    assign bus.mode     = mode_q;
    assign bus.sec_tick = sec_tick_q;
endmodule
